biasamp_trim_ctrl: RTL and testbench

- Digital successive-approximation (SAR) trim controller that sits directly upstream of the analog bias amplifier.
- Drives the amplifier's enable and its CODE_W-bit bias-trim DAC code.
- Reads the amplifier's on-chip comparator output (1 = amp output above reference) and binary-searches for the largest code at which the comparator reads 0.
- Provides a manual override path for bring-up.

---
 rtl/biasamp_pkg.sv | 20 ++
 rtl/biasamp_sync2.sv | 21 ++
 rtl/biasamp_trim_ctrl.sv | 150 +++++++++++++++
 tb/tb_biasamp_trim_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/biasamp_pkg.sv
// Shared types and constants for the bias-amplifier SAR trim controller.
package biasamp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DECIDE,
    DONE
  } state_t;

  localparam int VOTE_N = 3;
  localparam int VOTE_W = $clog2(VOTE_N + 1);

  // Mid-scale DAC code: the SAR search always starts with only the MSB set.
  function automatic int mid_scale(input int code_w);
    return 1 << (code_w - 1);
  endfunction

endpackage

// File: rtl/biasamp_sync2.sv
// Two-flop synchroniser for asynchronous analog status lines; resets to 0.
module biasamp_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/biasamp_trim_ctrl.sv
// SAR trim controller: binary-searches the bias DAC code for the largest code
// at which the amplifier comparator reads 0, with a manual override path.
module biasamp_trim_ctrl
  import biasamp_pkg::*;
#(
  parameter int CODE_W     = 6,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              comp_in,
  input  logic              override_en,
  input  logic [CODE_W-1:0] override_code,
  output logic [CODE_W-1:0] trim_code,
  output logic              amp_en,
  output logic              busy,
  output logic              done,
  output logic              valid
);

  localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYC);

  localparam logic [CODE_W-1:0] CODE_MID    = CODE_W'(mid_scale(CODE_W));
  localparam logic [BIT_W-1:0]  BIT_MSB     = BIT_W'(CODE_W - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [VOTE_W-1:0] VOTE_LAST   = VOTE_W'(VOTE_N - 1);
  localparam logic [VOTE_W-1:0] VOTE_MAJ    = VOTE_W'(VOTE_N / 2);

  state_t              state, state_nxt;
  logic [CODE_W-1:0]   code, code_nxt;
  logic [BIT_W-1:0]    bit_idx, bit_nxt;
  logic [CNT_W-1:0]    settle_cnt, settle_nxt;
  logic [VOTE_W-1:0]   vote_cnt, vote_nxt;
  logic [VOTE_W-1:0]   ones_cnt, ones_nxt;
  logic                busy_nxt, done_nxt, valid_nxt;
  logic                comp_s;
  logic                abort;

  biasamp_sync2 u_comp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (comp_in),
    .q     (comp_s)
  );

  assign trim_code = override_en ? override_code : code;
  assign abort     = !ena || override_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code       <= CODE_MID;
      bit_idx    <= BIT_MSB;
      settle_cnt <= '0;
      vote_cnt   <= '0;
      ones_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      amp_en     <= 1'b0;
    end else begin
      state      <= state_nxt;
      code       <= code_nxt;
      bit_idx    <= bit_nxt;
      settle_cnt <= settle_nxt;
      vote_cnt   <= vote_nxt;
      ones_cnt   <= ones_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      valid      <= valid_nxt;
      amp_en     <= ena;
    end
  end

  // done/valid/busy are registered, so they change on the edge leaving DONE.
  always_comb begin
    state_nxt  = state;
    code_nxt   = code;
    bit_nxt    = bit_idx;
    settle_nxt = settle_cnt;
    vote_nxt   = vote_cnt;
    ones_nxt   = ones_cnt;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    valid_nxt  = valid;

    case (state)
      IDLE: begin
        if (start && ena && !override_en) begin
          code_nxt   = CODE_MID;
          bit_nxt    = BIT_MSB;
          settle_nxt = SETTLE_LOAD;
          valid_nxt  = 1'b0;
          busy_nxt   = 1'b1;
          state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          vote_nxt  = '0;
          ones_nxt  = '0;
          state_nxt = SAMPLE;
        end else begin
          settle_nxt = settle_cnt - CNT_W'(1);
        end
      end
      SAMPLE: begin
        ones_nxt = ones_cnt + {{(VOTE_W-1){1'b0}}, comp_s};
        if (vote_cnt == VOTE_LAST) begin
          state_nxt = DECIDE;
        end else begin
          vote_nxt = vote_cnt + VOTE_W'(1);
        end
      end
      DECIDE: begin
        if (ones_cnt > VOTE_MAJ) begin
          code_nxt[bit_idx] = 1'b0;
        end
        if (bit_idx == '0) begin
          state_nxt = DONE;
        end else begin
          code_nxt[bit_idx - BIT_W'(1)] = 1'b1;
          bit_nxt    = bit_idx - BIT_W'(1);
          settle_nxt = SETTLE_LOAD;
          state_nxt  = SETTLE;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        valid_nxt = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort keeps the partially searched code so bring-up can inspect it.
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
      code_nxt  = code;
      busy_nxt  = 1'b0;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
    end
  end

endmodule

// File: tb/tb_biasamp_trim_ctrl.sv
// Scoreboard bench for biasamp_trim_ctrl: randomized comparator thresholds
// checked against an exhaustive "largest code reading 0" reference search.
module tb_biasamp_trim_ctrl;

  localparam int CODE_W     = 6;
  localparam int SETTLE_CYC = 4;
  localparam int VOTES      = 3;
  localparam int CAL_CYC    = CODE_W * (SETTLE_CYC + VOTES + 1) + 1;
  localparam int MAX_CODE   = (1 << CODE_W) - 1;

  typedef struct {
    int code;
    int cycle;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic              start;
  logic              comp_in;
  logic              override_en;
  logic [CODE_W-1:0] override_code;
  logic [CODE_W-1:0] trim_code;
  logic              amp_en;
  logic              busy;
  logic              done;
  logic              valid;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   thr_r  = 37;
  bit   glitch = 1'b0;
  int   last_code;
  exp_t exp_q[$];

  biasamp_trim_ctrl #(
    .CODE_W     (CODE_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .start         (start),
    .comp_in       (comp_in),
    .override_en   (override_en),
    .override_code (override_code),
    .trim_code     (trim_code),
    .amp_en        (amp_en),
    .busy          (busy),
    .done          (done),
    .valid         (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Analog comparator: high when the DAC code is above the threshold; the
  // glitch flag inverts it for a single cycle.
  always_comb comp_in = (int'(trim_code) > thr_r) ^ glitch;

  function automatic int refCode(input int thr);
    int res = 0;
    for (int c = 0; c <= MAX_CODE; c++) begin
      if (!(c > thr)) res = c;
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("done_cycle", cyc, e.cycle);
        checkOutput("final_code", int'(trim_code), e.code);
        checkOutput("valid_at_done", int'(valid), 1);
        checkOutput("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic pulseStart(output int k, input bit expect_accept, input int thr);
    thr_r = thr;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
    if (expect_accept) begin
      exp_q.push_back('{code: refCode(thr), cycle: k + CAL_CYC});
      last_code = refCode(thr);
    end
  endtask

  task automatic waitDrain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 4 * CAL_CYC) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("done_timeout", 0, 1);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int thr, input bit use_glitch, input bit extra_start);
    int k;
    pulseStart(k, 1'b1, thr);
    if (use_glitch) begin
      repeat (3) @(posedge clk);
      #1 glitch = 1'b1;
      @(posedge clk);
      #1 glitch = 1'b0;
    end else if (extra_start) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waitDrain();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int thr;
    rst_n         = 1'b0;
    ena           = 1'b0;
    start         = 1'b0;
    override_en   = 1'b0;
    override_code = '0;
    last_code     = 1 << (CODE_W - 1);
    repeat (3) @(negedge clk);

    checkOutput("reset_trim_code", int'(trim_code), 32);
    checkOutput("reset_amp_en", int'(amp_en), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #1 checkOutput("amp_en_follows", int'(amp_en), 1);

    $display("[TB] nominal and rail calibrations");
    applyStimulus(37, 1'b0, 1'b0);
    checkOutput("nominal_hold_code", int'(trim_code), 37);
    checkOutput("nominal_valid", int'(valid), 1);
    applyStimulus(MAX_CODE, 1'b0, 1'b0);
    applyStimulus(-1, 1'b0, 1'b0);
    applyStimulus(37, 1'b1, 1'b0);

    $display("[TB] randomized thresholds");
    for (int i = 0; i < 8; i++) begin
      thr = int'($urandom_range(MAX_CODE + 1)) - 1;
      applyStimulus(thr, 1'($urandom_range(1)), 1'b0);
    end

    $display("[TB] abort by ena");
    pulseStart(k, 1'b0, 37);
    checkOutput("busy_after_start", int'(busy), 1);
    checkOutput("valid_cleared_on_start", int'(valid), 0);
    while (cyc < k + 20) @(negedge clk);
    ena = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_valid", int'(valid), 0);
    checkOutput("abort_amp_en", int'(amp_en), 0);
    repeat (CAL_CYC + 10) @(negedge clk);
    checkOutput("abort_valid_late", int'(valid), 0);
    ena = 1'b1;
    @(negedge clk);
    applyStimulus(37, 1'b0, 1'b0);

    $display("[TB] manual override");
    override_en   = 1'b1;
    override_code = 6'd12;
    #1 checkOutput("override_mux", int'(trim_code), 12);
    pulseStart(k, 1'b0, 37);
    repeat (10) @(negedge clk);
    checkOutput("override_start_ignored", int'(busy), 0);
    checkOutput("override_mux_hold", int'(trim_code), 12);
    override_en = 1'b0;
    #1 checkOutput("override_release", int'(trim_code), last_code);

    pulseStart(k, 1'b0, 20);
    while (cyc < k + 10) @(negedge clk);
    override_en   = 1'b1;
    override_code = 6'd5;
    #1 checkOutput("override_midrun_mux", int'(trim_code), 5);
    @(posedge clk);
    #1;
    checkOutput("override_abort_busy", int'(busy), 0);
    checkOutput("override_abort_valid", int'(valid), 0);
    override_en = 1'b0;
    #1 checkOutput("override_partial_code", int'(trim_code), (refCode(20) & 32) | 16);
    repeat (CAL_CYC + 10) @(negedge clk);

    $display("[TB] start while busy");
    applyStimulus(44, 1'b0, 1'b1);

    $display("[TB] asynchronous reset mid-run");
    pulseStart(k, 1'b1, 37);
    while (cyc < k + 15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("midrst_trim_code", int'(trim_code), 32);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_valid", int'(valid), 0);
    checkOutput("midrst_amp_en", int'(amp_en), 0);
    checkOutput("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (CAL_CYC + 5) @(negedge clk);
    checkOutput("midrst_stays_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
